// File: rtl/colenda_pkg.sv
// Shared definitions for the instruction reader: opcodes, field
// positions inside dataA and the reader FSM state encoding.
package colenda_pkg;

   localparam logic [3:0] OP_WBR = 4'h0;
   localparam logic [3:0] OP_WSM = 4'h1;
   localparam logic [3:0] OP_WBM = 4'h2;
   localparam logic [3:0] OP_DP  = 4'h3;

   localparam int OPC_LSB = 0;
   localparam int OPC_W   = 4;
   localparam int FLD_LSB = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_POP,
      S_LATCH,
      S_EXEC
   } state_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of one dataA word into a one-hot strobe
// select and the address field of every target.
module instr_decode
   import colenda_pkg::*;
#(
   parameter int REG_ADDR_W  = 5,
   parameter int SPR_ADDR_W  = 14,
   parameter int BG_ADDR_W   = 12,
   parameter int POLY_ADDR_W = 4
) (
   input  logic [31:0]            instr_i,
   output logic                   is_reg_o,
   output logic                   is_spr_o,
   output logic                   is_bg_o,
   output logic                   is_poly_o,
   output logic                   is_bad_o,
   output logic [REG_ADDR_W-1:0]  reg_addr_o,
   output logic [SPR_ADDR_W-1:0]  spr_addr_o,
   output logic [BG_ADDR_W-1:0]   bg_addr_o,
   output logic [POLY_ADDR_W-1:0] poly_addr_o
);

   logic [OPC_W-1:0] opc;
   logic             unused_hi;

   assign opc         = instr_i[OPC_LSB +: OPC_W];
   assign reg_addr_o  = instr_i[FLD_LSB +: REG_ADDR_W];
   assign spr_addr_o  = instr_i[FLD_LSB +: SPR_ADDR_W];
   assign bg_addr_o   = instr_i[FLD_LSB +: BG_ADDR_W];
   assign poly_addr_o = instr_i[FLD_LSB +: POLY_ADDR_W];
   assign unused_hi   = ^instr_i[31:FLD_LSB+SPR_ADDR_W];

   // Opcode to one-hot target select; anything unknown is illegal.
   always_comb begin
      is_reg_o  = 1'b0;
      is_spr_o  = 1'b0;
      is_bg_o   = 1'b0;
      is_poly_o = 1'b0;
      is_bad_o  = 1'b0;
      unique case (opc)
         OP_WBR:  is_reg_o  = 1'b1;
         OP_WSM:  is_spr_o  = 1'b1;
         OP_WBM:  is_bg_o   = 1'b1;
         OP_DP:   is_poly_o = 1'b1;
         default: is_bad_o  = 1'b1;
      endcase
   end

endmodule

// File: rtl/instruction_reader.sv
// Read side of the dataA/dataB instruction FIFO pair: pop, latch, decode
// and issue one write strobe. Optional stats ports under INSTR_STATS_EN.
module instruction_reader
   import colenda_pkg::*;
#(
   parameter int REG_ADDR_W  = 5,
   parameter int SPR_ADDR_W  = 14,
   parameter int BG_ADDR_W   = 12,
   parameter int POLY_ADDR_W = 4,
   parameter int COLOR_W     = 9
) (
   input  logic                   clk_100,
   input  logic                   reset,
   input  logic                   rdempty,
   input  logic [31:0]            dataA,
   input  logic [31:0]            dataB,
   input  logic                   allow_write,
   output logic                   out_rdreq,
   output logic                   reg_wr,
   output logic [REG_ADDR_W-1:0]  reg_addr,
   output logic [31:0]            reg_data,
   output logic                   spr_wr,
   output logic [SPR_ADDR_W-1:0]  spr_addr,
   output logic                   bg_wr,
   output logic [BG_ADDR_W-1:0]   bg_addr,
   output logic [COLOR_W-1:0]     mem_data,
   output logic                   poly_wr,
   output logic [POLY_ADDR_W-1:0] poly_addr,
`ifdef INSTR_STATS_EN
   output logic [15:0]            instr_count,
   output logic [7:0]             err_count,
`endif
   output logic                   bad_op
);

   state_t state_q;

   logic                   go_d;
   logic                   is_reg;
   logic                   is_spr;
   logic                   is_bg;
   logic                   is_poly;
   logic                   is_bad;
   logic [REG_ADDR_W-1:0]  dec_reg_addr;
   logic [SPR_ADDR_W-1:0]  dec_spr_addr;
   logic [BG_ADDR_W-1:0]   dec_bg_addr;
   logic [POLY_ADDR_W-1:0] dec_poly_addr;

   assign go_d = !rdempty && allow_write;

   // FIFO q is valid during LATCH, so decode it live and
   // register the result into the outputs on the way to EXEC.
   instr_decode #(
      .REG_ADDR_W  (REG_ADDR_W),
      .SPR_ADDR_W  (SPR_ADDR_W),
      .BG_ADDR_W   (BG_ADDR_W),
      .POLY_ADDR_W (POLY_ADDR_W)
   ) u_decode (
      .instr_i     (dataA),
      .is_reg_o    (is_reg),
      .is_spr_o    (is_spr),
      .is_bg_o     (is_bg),
      .is_poly_o   (is_poly),
      .is_bad_o    (is_bad),
      .reg_addr_o  (dec_reg_addr),
      .spr_addr_o  (dec_spr_addr),
      .bg_addr_o   (dec_bg_addr),
      .poly_addr_o (dec_poly_addr)
   );

   // Reader FSM with registered request, strobes and held fields.
   always_ff @(posedge clk_100) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         out_rdreq <= 1'b0;
         reg_wr    <= 1'b0;
         reg_addr  <= '0;
         reg_data  <= '0;
         spr_wr    <= 1'b0;
         spr_addr  <= '0;
         bg_wr     <= 1'b0;
         bg_addr   <= '0;
         mem_data  <= '0;
         poly_wr   <= 1'b0;
         poly_addr <= '0;
         bad_op    <= 1'b0;
      end else begin
         out_rdreq <= 1'b0;
         reg_wr    <= 1'b0;
         spr_wr    <= 1'b0;
         bg_wr     <= 1'b0;
         poly_wr   <= 1'b0;
         bad_op    <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (go_d) begin
                  state_q   <= S_POP;
                  out_rdreq <= 1'b1;
               end
            end
            S_POP: begin
               state_q <= S_LATCH;
            end
            S_LATCH: begin
               state_q <= S_EXEC;
               if (is_reg) begin
                  reg_wr   <= 1'b1;
                  reg_addr <= dec_reg_addr;
                  reg_data <= dataB;
               end
               if (is_spr) begin
                  spr_wr   <= 1'b1;
                  spr_addr <= dec_spr_addr;
                  mem_data <= dataB[COLOR_W-1:0];
               end
               if (is_bg) begin
                  bg_wr    <= 1'b1;
                  bg_addr  <= dec_bg_addr;
                  mem_data <= dataB[COLOR_W-1:0];
               end
               if (is_poly) begin
                  poly_wr   <= 1'b1;
                  poly_addr <= dec_poly_addr;
                  reg_data  <= dataB;
               end
               if (is_bad) begin
                  bad_op <= 1'b1;
               end
            end
            S_EXEC: begin
               if (go_d) begin
                  state_q   <= S_POP;
                  out_rdreq <= 1'b1;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

`ifdef INSTR_STATS_EN
   // Legal executions wrap; illegal opcodes saturate.
   always_ff @(posedge clk_100) begin
      if (!reset) begin
         instr_count <= '0;
         err_count   <= '0;
      end else if (state_q == S_LATCH) begin
         if (is_bad) begin
            if (err_count != 8'hFF) begin
               err_count <= err_count + 8'd1;
            end
         end else begin
            instr_count <= instr_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_instruction_reader.sv
// Self-checking bench for instruction_reader: FIFO emulation, a
// schedule-based reference model and directed literal checks.
module tb_instruction_reader;

   logic        clk_100 = 1'b0;
   logic        reset;
   logic        rdempty;
   logic [31:0] dataA;
   logic [31:0] dataB;
   logic        allow_write;
   logic        out_rdreq;
   logic        reg_wr;
   logic [4:0]  reg_addr;
   logic [31:0] reg_data;
   logic        spr_wr;
   logic [13:0] spr_addr;
   logic        bg_wr;
   logic [11:0] bg_addr;
   logic [8:0]  mem_data;
   logic        poly_wr;
   logic [3:0]  poly_addr;
   logic        bad_op;

   instruction_reader dut (
      .clk_100     (clk_100),
      .reset       (reset),
      .rdempty     (rdempty),
      .dataA       (dataA),
      .dataB       (dataB),
      .allow_write (allow_write),
      .out_rdreq   (out_rdreq),
      .reg_wr      (reg_wr),
      .reg_addr    (reg_addr),
      .reg_data    (reg_data),
      .spr_wr      (spr_wr),
      .spr_addr    (spr_addr),
      .bg_wr       (bg_wr),
      .bg_addr     (bg_addr),
      .mem_data    (mem_data),
      .poly_wr     (poly_wr),
      .poly_addr   (poly_addr),
      .bad_op      (bad_op)
   );

   always #5 clk_100 = ~clk_100;

   logic [31:0] fa [64];
   logic [31:0] fb [64];
   int wr_ptr = 0;
   int env_rd = 0;
   int m_head = 0;

   assign rdempty = (env_rd == wr_ptr);

   logic        e_rdreq = 0, e_reg_wr = 0, e_spr_wr = 0;
   logic        e_bg_wr = 0, e_poly_wr = 0, e_bad = 0;
   logic [4:0]  e_reg_addr = 0;
   logic [31:0] e_reg_data = 0;
   logic [13:0] e_spr_addr = 0;
   logic [11:0] e_bg_addr = 0;
   logic [8:0]  e_mem = 0;
   logic [3:0]  e_poly_addr = 0;

   longint ecount = 0;
   longint pop_e = 0;
   longint free_e = 0;
   bit     in_flight = 0;
   logic [31:0] cur_a, cur_b;

   // Reference model: a pop at edge t shows its strobe after edge t+2
   // and the reader may decide again at edge t+3.
   always @(posedge clk_100) begin
      ecount++;
      e_rdreq = 0; e_reg_wr = 0; e_spr_wr = 0;
      e_bg_wr = 0; e_poly_wr = 0; e_bad = 0;
      if (!reset) begin
         e_reg_addr = 0; e_reg_data = 0; e_spr_addr = 0;
         e_bg_addr = 0; e_mem = 0; e_poly_addr = 0;
         in_flight = 0; free_e = 0;
      end else begin
         if (in_flight && ecount == pop_e + 2) begin
            in_flight = 0;
            case (cur_a % 16)
               0: begin
                  e_reg_wr = 1;
                  e_reg_addr = 5'((cur_a >> 4) % 32);
                  e_reg_data = cur_b;
               end
               1: begin
                  e_spr_wr = 1;
                  e_spr_addr = 14'((cur_a >> 4) % 16384);
                  e_mem = 9'(cur_b % 512);
               end
               2: begin
                  e_bg_wr = 1;
                  e_bg_addr = 12'((cur_a >> 4) % 4096);
                  e_mem = 9'(cur_b % 512);
               end
               3: begin
                  e_poly_wr = 1;
                  e_poly_addr = 4'((cur_a >> 4) % 16);
                  e_reg_data = cur_b;
               end
               default: e_bad = 1;
            endcase
         end
         if (ecount >= free_e && !rdempty && allow_write) begin
            e_rdreq = 1;
            pop_e = ecount;
            free_e = ecount + 3;
            in_flight = 1;
            cur_a = fa[m_head];
            cur_b = fb[m_head];
            m_head++;
         end
      end
   end

   logic [81:0] act_v, exp_v;
   assign act_v = {out_rdreq, reg_wr, reg_addr, reg_data, spr_wr,
                   spr_addr, bg_wr, bg_addr, mem_data, poly_wr,
                   poly_addr, bad_op};
   assign exp_v = {e_rdreq, e_reg_wr, e_reg_addr, e_reg_data, e_spr_wr,
                   e_spr_addr, e_bg_wr, e_bg_addr, e_mem, e_poly_wr,
                   e_poly_addr, e_bad};

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [81:0] act,
                      input logic [81:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b);
      fa[wr_ptr] = a;
      fb[wr_ptr] = b;
      wr_ptr++;
   endtask

   // One cycle: compare against the model, then let the FIFO respond.
   task automatic tick();
      @(negedge clk_100);
      chk("cycle", act_v, exp_v);
      if (out_rdreq && env_rd < wr_ptr) begin
         dataA = fa[env_rd];
         dataB = fb[env_rd];
         env_rd++;
      end
   endtask

   function automatic logic sel(input int which);
      case (which)
         0:       return out_rdreq;
         1:       return reg_wr;
         2:       return spr_wr;
         3:       return bg_wr;
         4:       return poly_wr;
         default: return bad_op;
      endcase
   endfunction

   task automatic wait_sig(input int which, input int maxc,
                           output int n);
      n = -1;
      for (int i = 1; i <= maxc; i++) begin
         tick();
         if (sel(which) && n < 0) begin
            n = i;
            break;
         end
      end
   endtask

   int n;

   initial begin
      reset = 0;
      allow_write = 1;
      dataA = 0;
      dataB = 0;
      push(32'h0000_0050, 32'hDEAD_BEEF);
      repeat (3) begin
         tick();
         chk("rst_rdreq", 82'(out_rdreq), 82'd0);
         chk("rst_outs", act_v, 82'd0);
      end
      reset = 1;

      wait_sig(0, 5, n);
      chk("wbr_pop_lat", 82'(n), 82'(1));
      wait_sig(1, 5, n);
      chk("wbr_strobe_lat", 82'(n), 82'(2));
      chk("wbr_addr", 82'(reg_addr), 82'd5);
      chk("wbr_data", 82'(reg_data), 82'hDEADBEEF);

      push(32'h0003_FFF1, 32'h0000_00A5);
      push(32'h0000_ABC2, 32'h0000_01FF);
      wait_sig(0, 5, n);
      chk("wsm_pop_lat", 82'(n), 82'(1));
      wait_sig(2, 5, n);
      chk("wsm_strobe_lat", 82'(n), 82'(2));
      chk("wsm_addr", 82'(spr_addr), 82'h3FFF);
      chk("wsm_data", 82'(mem_data), 82'h0A5);
      wait_sig(0, 5, n);
      chk("pop_spacing", 82'(n + 2), 82'(3));
      wait_sig(3, 5, n);
      chk("wbm_addr", 82'(bg_addr), 82'hABC);
      chk("wbm_data", 82'(mem_data), 82'h1FF);
      chk("wbm_spr_hold", 82'(spr_addr), 82'h3FFF);

      push(32'h0000_000F, 32'h1234_5678);
      wait_sig(5, 6, n);
      chk("bad_lat", 82'(n), 82'(3));
      chk("bad_nostrobe", 82'({reg_wr, spr_wr, bg_wr, poly_wr}), 82'd0);
      chk("bad_hold", 82'(reg_data), 82'hDEADBEEF);
      tick();
      chk("bad_pulse", 82'(bad_op), 82'd0);

      allow_write = 0;
      push(32'h0000_00A0, 32'h1111_1111);
      push(32'h0000_0093, 32'hCAFE_F00D);
      wait_sig(0, 6, n);
      chk("blocked_nopop", 82'(n), 82'(-1));
      allow_write = 1;
      wait_sig(0, 3, n);
      chk("grant_pop", 82'(n), 82'(1));
      tick();
      allow_write = 0;
      wait_sig(1, 3, n);
      chk("drop_strobe", 82'(n), 82'(1));
      chk("drop_addr", 82'(reg_addr), 82'd10);
      wait_sig(0, 6, n);
      chk("drop_nopop", 82'(n), 82'(-1));
      allow_write = 1;
      wait_sig(4, 6, n);
      chk("dp_lat", 82'(n), 82'(3));
      chk("dp_addr", 82'(poly_addr), 82'd9);
      chk("dp_data", 82'(reg_data), 82'hCAFEF00D);

      push(32'h0000_01F0, 32'h5555_5555);
      wait_sig(0, 3, n);
      chk("rst6_pop", 82'(n), 82'(1));
      tick();
      reset = 0;
      tick();
      chk("rst6_clear", act_v, 82'd0);
      reset = 1;
      wait_sig(1, 6, n);
      chk("rst6_nostrobe", 82'(n), 82'(-1));
      push(32'h0000_0012, 32'h0000_00AB);
      wait_sig(3, 6, n);
      chk("post_rst_lat", 82'(n), 82'(3));
      chk("post_rst_addr", 82'(bg_addr), 82'd1);
      chk("post_rst_data", 82'(mem_data), 82'h0AB);
      chk("post_rst_spr", 82'(spr_addr), 82'd0);

      repeat (4) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
